// File: rtl/tp_pkg.sv
// -----------------------------------------------------------------------------
// tp_pkg
// Shared definitions for the test-point signal conditioner: default test-point
// width, page-select width, blanking FSM state encoding, stretch counter width
// and the width of the rising-edge counter.
// -----------------------------------------------------------------------------
package tp_pkg;

  localparam int NUM_TP_DEF = 16;  // default test-point output width
  localparam int NUM_PAGES  = 4;   // SIG_IN carries four pages
  localparam int PAGE_W     = 2;   // width of PAGE_SEL / PAGE_ACT
  localparam int STRETCH_W  = 4;   // width of STRETCH_LEN and per-bit counters
  localparam int CNT_SEL_W  = 4;   // width of CNT_SEL
  localparam int EDGE_CNT_W = 16;  // width of the saturating edge counter

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } tp_state_e;

endpackage

// File: rtl/tp_signal_conditioner_if.sv
// -----------------------------------------------------------------------------
// tp_signal_conditioner_if
// Bundles the data/control signals of the test-point signal conditioner.
//   SIG_IN      raw debug signals, four pages of NUM_TP bits each
//   PAGE_SEL    requested page
//   STRETCH_EN  per-bit pulse stretch enable
//   STRETCH_LEN extra high cycles appended after a rising edge
//   CNT_SEL     TP_OUT bit whose rising edges are counted
//   CNT_CLR     synchronous clear of EDGE_CNT
//   TP_OUT      conditioned test-point data
//   PAGE_ACT    page currently driven
//   SWITCHING   high while the output is blanked for a page change
//   EDGE_CNT    saturating rising-edge count
// master: the side driving the raw signals/controls; slave: the conditioner.
// -----------------------------------------------------------------------------
interface tp_signal_conditioner_if
  import tp_pkg::*;
#(
  parameter int NUM_TP = NUM_TP_DEF
) ();

  logic [NUM_PAGES*NUM_TP-1:0] SIG_IN;
  logic [PAGE_W-1:0]           PAGE_SEL;
  logic [NUM_TP-1:0]           STRETCH_EN;
  logic [STRETCH_W-1:0]        STRETCH_LEN;
  logic [CNT_SEL_W-1:0]        CNT_SEL;
  logic                        CNT_CLR;
  logic [NUM_TP-1:0]           TP_OUT;
  logic [PAGE_W-1:0]           PAGE_ACT;
  logic                        SWITCHING;
  logic [EDGE_CNT_W-1:0]       EDGE_CNT;

  modport master (
    output SIG_IN, PAGE_SEL, STRETCH_EN, STRETCH_LEN, CNT_SEL, CNT_CLR,
    input  TP_OUT, PAGE_ACT, SWITCHING, EDGE_CNT
  );

  modport slave (
    input  SIG_IN, PAGE_SEL, STRETCH_EN, STRETCH_LEN, CNT_SEL, CNT_CLR,
    output TP_OUT, PAGE_ACT, SWITCHING, EDGE_CNT
  );

endinterface

// File: rtl/tp_stretch.sv
// -----------------------------------------------------------------------------
// tp_stretch
// One test-point bit: rising-edge detect against the previous sample, a
// retriggerable 4-bit stretch counter and the OR-ed output.
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear of edge history and counter
//   din         current sample of the bit (active page, stage 1)
//   en          stretch enable for this bit
//   len         extra high cycles loaded on a rising edge
//   dout        din OR (counter != 0), combinational
// -----------------------------------------------------------------------------
module tp_stretch
  import tp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 din,
  input  logic                 en,
  input  logic [STRETCH_W-1:0] len,
  output logic                 dout
);

  logic                 hist_p1;
  logic [STRETCH_W-1:0] cnt_p1;
  logic                 rise;

  assign rise = din & ~hist_p1;

  // stage 1 -> 2: edge history and stretch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else if (clr) begin
      hist_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      hist_p1 <= din;
      // A rise reloads even while counting, so close pulses merge.
      if (rise && en)
        cnt_p1 <= len;
      else if (cnt_p1 != '0)
        cnt_p1 <= cnt_p1 - 1'b1;
    end
  end

  assign dout = din | (cnt_p1 != '0);

endmodule

// File: rtl/tp_signal_conditioner.sv
// -----------------------------------------------------------------------------
// tp_signal_conditioner
// Selects one of four pages of raw debug signals, stretches short pulses per
// bit, blanks the outputs for BLANK_CYC cycles on every page change and counts
// rising edges of one selected output bit.
//   CLK       single clock, rising edge
//   RST_B     asynchronous active-low reset (already synchronised upstream)
//   bus       tp_signal_conditioner_if.slave: SIG_IN, PAGE_SEL, STRETCH_EN,
//             STRETCH_LEN, CNT_SEL, CNT_CLR in; TP_OUT, PAGE_ACT, SWITCHING,
//             EDGE_CNT out
// Latency SIG_IN -> TP_OUT is two cycles (input register, output register).
// -----------------------------------------------------------------------------
module tp_signal_conditioner
  import tp_pkg::*;
#(
  parameter int NUM_TP    = NUM_TP_DEF,
  parameter int BLANK_CYC = 4          // legal 1..15
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  tp_signal_conditioner_if.slave bus
);

  localparam logic [STRETCH_W-1:0] BLANK_LOAD = STRETCH_W'(BLANK_CYC - 1);

  logic [NUM_PAGES*NUM_TP-1:0] sig_p1;
  logic [PAGE_W-1:0]           page_sel_p1;
  logic [PAGE_W-1:0]           page_sel_p2;
  logic [NUM_TP-1:0]           page_data;
  logic [NUM_TP-1:0]           cond;
  logic [NUM_TP-1:0]           tp_out_p2;
  logic [NUM_TP-1:0]           tp_hist_p3;
  logic [PAGE_W-1:0]           page_act;
  logic [STRETCH_W-1:0]        blank_cnt;
  tp_state_e                   state;
  tp_state_e                   state_nxt;
  logic                        blanking;
  logic                        load_blank;
  logic                        commit_page;
  logic                        cnt_edge;
  logic [EDGE_CNT_W-1:0]       edge_cnt;

  function automatic logic [EDGE_CNT_W-1:0] sat_inc(input logic [EDGE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // stage 0 -> 1: raw inputs and requested page
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      sig_p1      <= '0;
      page_sel_p1 <= '0;
      page_sel_p2 <= '0;
    end else begin
      sig_p1      <= bus.SIG_IN;
      page_sel_p1 <= bus.PAGE_SEL;
      page_sel_p2 <= page_sel_p1;
    end
  end

  assign page_data = sig_p1[page_act*NUM_TP +: NUM_TP];

  for (genvar i = 0; i < NUM_TP; i++) begin : g_bit
    tp_stretch u_stretch (
      .clk   (CLK),
      .rst_n (RST_B),
      .clr   (blanking),
      .din   (page_data[i]),
      .en    (bus.STRETCH_EN[i]),
      .len   (bus.STRETCH_LEN),
      .dout  (cond[i])
    );
  end

  // Page-switch FSM: state register
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  // Page-switch FSM: next state. A request that moves again while blanking
  // restarts the blank period, so intermediate pages are never driven.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (page_sel_p1 != page_act) state_nxt = ST_BLANK;
      ST_BLANK: if ((page_sel_p1 == page_sel_p2) && (blank_cnt == '0)) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Page-switch FSM: outputs
  always_comb begin
    blanking    = 1'b0;
    load_blank  = 1'b0;
    commit_page = 1'b0;
    case (state)
      ST_RUN: begin
        load_blank = (page_sel_p1 != page_act);
      end
      ST_BLANK: begin
        blanking    = 1'b1;
        load_blank  = (page_sel_p1 != page_sel_p2);
        commit_page = !load_blank && (blank_cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      blank_cnt <= '0;
      page_act  <= '0;
    end else begin
      if (load_blank)
        blank_cnt <= BLANK_LOAD;
      else if (blanking && (blank_cnt != '0))
        blank_cnt <= blank_cnt - 1'b1;
      if (commit_page)
        page_act <= page_sel_p1;
    end
  end

  // stage 1 -> 2: conditioned output; stage 2 -> 3: history for edge counting
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      tp_out_p2  <= '0;
      tp_hist_p3 <= '0;
    end else begin
      tp_out_p2  <= blanking ? '0 : cond;
      tp_hist_p3 <= tp_out_p2;
    end
  end

  // History is per bit, so changing CNT_SEL never pairs one bit's current
  // value with another bit's past value.
  always_comb begin
    cnt_edge = 1'b0;
    if (!blanking && (int'(bus.CNT_SEL) < NUM_TP))
      cnt_edge = tp_out_p2[bus.CNT_SEL] && !tp_hist_p3[bus.CNT_SEL];
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)
      edge_cnt <= '0;
    else if (bus.CNT_CLR)
      edge_cnt <= '0;
    else if (cnt_edge)
      edge_cnt <= sat_inc(edge_cnt);
  end

  assign bus.TP_OUT    = tp_out_p2;
  assign bus.PAGE_ACT  = page_act;
  assign bus.SWITCHING = blanking;
  assign bus.EDGE_CNT  = edge_cnt;

endmodule
